hilo_muldiv_ctrl: RTL

- Multi-cycle sequencer for the HI/LO arithmetic group: MULT/MULTU/DIV/DIVU and MADD/MADDU/MSUB/MSUBU.
- Sits beside the execute stage. Decode supplies already-forwarded operands plus HI/LO values.
- The block stalls the pipeline while an operation is outstanding, then issues a single HI/LO write-back pulse.
- Division is radix-2 restoring, 1 bit/cycle. Multiply is a fixed-latency pipeline, depth set by parameter.

---
 rtl/hilo_muldiv_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO arithmetic sequencer: multi-cycle MULT/DIV/MADD/MSUB with pipeline
// stall and a single write-back pulse per completed operation.
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT  = 3,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic        stall,
  output logic        done,
  output logic        hi_w,
  output logic        lo_w,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_ITER - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_out_q, hi_out_d;
  logic [31:0] lo_out_q, lo_out_d;

  // Operands latched at accept
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;

  // Restoring divider state: partial remainder, dividend/quotient shifter, divisor
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        qneg_q, rneg_q;

  logic        accept;
  logic        div_op;
  logic [32:0] shl, diff;
  logic        step_ok;
  logic [31:0] rem_nx, quo_nx;

  // 64-bit product, optionally accumulated into / subtracted from {hi,lo}.
  // op[0]=0 selects signed operands; op[2] selects accumulate; op[1] subtract.
  function automatic logic [63:0] mul_result(input logic [2:0]  f_op,
                                             input logic [31:0] fa,
                                             input logic [31:0] fb,
                                             input logic [31:0] fhi,
                                             input logic [31:0] flo);
    logic signed [63:0] ax, bx, prod;
    logic [63:0]        acc;
    ax   = (!f_op[0]) ? {{32{fa[31]}}, fa} : {32'd0, fa};
    bx   = (!f_op[0]) ? {{32{fb[31]}}, fb} : {32'd0, fb};
    prod = ax * bx;
    acc  = {fhi, flo};
    if (!f_op[2])     mul_result = prod;
    else if (f_op[1]) mul_result = acc - prod;
    else              mul_result = acc + prod;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x, input logic en);
    abs32 = (en && x[31]) ? -x : x;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] x, input logic en);
    neg_if = en ? -x : x;
  endfunction

  // One restoring step: shift in next dividend bit, subtract divisor if it fits
  always_comb begin
    shl     = {rem_q, quo_q[31]};
    diff    = shl - {1'b0, dvs_q};
    step_ok = ~diff[32];
    rem_nx  = step_ok ? diff[31:0] : shl[31:0];
    quo_nx  = {quo_q[30:0], step_ok};
  end

  // Next-state, stall/done and result selection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_out_d = hi_out_q;
    lo_out_d = lo_out_q;
    stall    = 1'b0;
    done     = 1'b0;
    accept   = start && !flush && (state_q == S_IDLE || state_q == S_DONE);
    div_op   = (op[2:1] == 2'b01);

    case (state_q)
      S_MUL: begin
        stall = 1'b1;
        if (cnt_q == MUL_LAST) begin
          state_d              = S_DONE;
          {hi_out_d, lo_out_d} = mul_result(op_q, a_q, b_q, hi_q, lo_q);
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DIV: begin
        stall = 1'b1;
        if (cnt_q == DIV_LAST) begin
          state_d  = S_DONE;
          lo_out_d = neg_if(quo_nx, qneg_q);
          hi_out_d = neg_if(rem_nx, rneg_q);
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      stall = 1'b1;
      cnt_d = 6'd0;
      if (div_op) begin
        if (b == 32'd0) begin
          state_d  = S_DONE;
          hi_out_d = a;
          lo_out_d = 32'hFFFF_FFFF;
        end else begin
          state_d = S_DIV;
        end
      end else if (MUL_LAT == 1) begin
        state_d              = S_DONE;
        {hi_out_d, lo_out_d} = mul_result(op, a, b, hi_in, lo_in);
      end else begin
        state_d = S_MUL;
        cnt_d   = 6'd1;
      end
    end

    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = 6'd0;
      hi_out_d = hi_out_q;
      lo_out_d = lo_out_q;
      stall    = 1'b0;
      done     = 1'b0;
    end
  end

  // Control state and registered results
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      hi_out_q <= 32'd0;
      lo_out_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_out_q <= hi_out_d;
      lo_out_q <= lo_out_d;
    end
  end

  // Operand capture at accept; divider iterates while in DIV
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op;
      a_q    <= a;
      b_q    <= b;
      hi_q   <= hi_in;
      lo_q   <= lo_in;
      rem_q  <= 32'd0;
      quo_q  <= abs32(a, ~op[0]);
      dvs_q  <= abs32(b, ~op[0]);
      qneg_q <= ~op[0] & (a[31] ^ b[31]);
      rneg_q <= ~op[0] & a[31];
    end else if (state_q == S_DIV) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

  assign hi_w   = done;
  assign lo_w   = done;
  assign hi_out = hi_out_q;
  assign lo_out = lo_out_q;

endmodule
